day4_scan_sched: RTL and testbench
==================================

# day4_scan_sched

Sequencer for the Day 4 grid datapath. It walks the grid ROM in row-major order and tags each returned cell with row/column and pass-boundary flags. In Part 2 mode it re-runs full sweeps until the datapath reports zero removals. It sits between the top-level start/done interface and the ROM plus neighbour-count/accumulator pipeline.

## Interface
Parameters:
- ROWS, 140, grid height in cells
- COLS, 140, grid width in cells
- ADDR_W, 15, ROM address width; must satisfy ROWS*COLS <= 2^ADDR_W
- ROW_W, 8, row index width
- COL_W, 8, column index width
- PASS_W, 8, pass counter width
- MAX_PASSES, 255, sweep limit in Part 2 mode

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- mode  in  1  0 = Part 1 (one sweep), 1 = Part 2 (repeat sweeps); sampled with start
- rd_ready  in  1  datapath can accept a cell read this cycle
- pass_done_in  in  1  datapath pipeline drained; pass_removed valid this cycle
- pass_removed  in  32  cells removed or counted in the pass just finished
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- cell_valid  out  1  ROM data for (cell_row, cell_col) is valid this cycle
- cell_row  out  ROW_W  row of the current cell
- cell_col  out  COL_W  column of the current cell
- pass_first  out  1  qualifies cell_valid at (0,0)
- pass_last  out  1  qualifies cell_valid at (ROWS-1, COLS-1)
- busy  out  1  state is not IDLE and not DONE
- done  out  1  run complete; held until next start or rst
- pass_count  out  PASS_W  number of completed sweeps
- overflow  out  1  Part 2 stopped at MAX_PASSES with removals still nonzero

## Operation
- States: IDLE, SCAN, DRAIN, DECIDE, DONE.
- IDLE/DONE with start=1:
  - go to SCAN
  - latch mode
  - clear pass_count, overflow, done, row, col, addr
- SCAN:
  - rom_en = rd_ready (combinational from state).
  - On each rom_en cycle, advance addr by 1, col by 1. At col=COLS-1, col wraps to 0 and row increments.
  - No multiplier: addr is a running counter.
  - The rom_en cycle at addr ROWS*COLS-1 moves the state to DRAIN.
- DRAIN:
  - Wait for pass_done_in. Then increment pass_count, capture pass_removed, go to DECIDE.
- DECIDE:
  - mode=0 -> DONE.
  - mode=1 and removed=0 -> DONE.
  - mode=1 and pass_count=MAX_PASSES -> DONE with overflow=1.
  - Otherwise clear row/col/addr and return to SCAN.
- DONE: done=1; wait for start.
- pass_done_in outside DRAIN is ignored.
- start in SCAN/DRAIN/DECIDE is ignored.
- mode changes mid-run are ignored.
- pass_count saturates at 2^PASS_W-1. It never wraps.

## Timing
- Reset values:
  - state IDLE
  - rom_en 0, rom_addr 0
  - cell_valid 0, cell_row 0, cell_col 0
  - pass_first 0, pass_last 0
  - busy 0, done 0
  - pass_count 0, overflow 0
- rst mid-run: every output returns to its reset value on the next edge. rom_en is 0 in the cycle after rst is sampled, and no further cell_valid is issued.
- ROM read latency is 1 cycle.
  - cell_valid, cell_row, cell_col, pass_first and pass_last are registered copies of the rom_en-cycle values.
  - They appear exactly one cycle after the matching rom_en.
- start sampled at edge t: SCAN from t+1, first rom_en at t+1 (if rd_ready).
- Sweep length with rd_ready held at 1: ROWS*COLS consecutive rom_en cycles.
- Stalls (rd_ready=0) insert gaps without skipping or repeating addresses.
- pass_done_in at edge d in DRAIN: DECIDE at d+1.
  - Either DONE at d+2 (done=1, busy=0),
  - or SCAN at d+2 with the first rom_en of the next sweep at address 0.
- busy is combinational from state. done is registered state-decoded and stays high in DONE.

## Test plan
Unless stated otherwise: ROWS=3, COLS=4, rd_ready=1.
- Part 1 basic sweep.
  - Stimulus: mode=0, start pulse.
  - Response: 12 consecutive rom_en cycles with addresses 0..11. cell_valid trails each by 1 cycle with (r,c) = (0,0)..(2,3). pass_first on the first cell only, pass_last on the last cell only. pass_done_in pulse gives done=1 two cycles later, pass_count=1, overflow=0.
- Backpressure.
  - Stimulus: rd_ready alternating 1,0.
  - Response: addresses 0..11, each issued exactly once, in order; last rom_en at cycle 23 after SCAN entry; cell_valid count 12.
- Part 2 convergence.
  - Stimulus: mode=1; pass_removed 5, 2, 0 on successive pass_done_in.
  - Response: three full sweeps, each restarting at address 0 with pass_first; done with pass_count=3, overflow=0.
- Part 2 limit.
  - Stimulus: MAX_PASSES=2; pass_removed always 1.
  - Response: exactly 2 sweeps; done=1, pass_count=2, overflow=1.
- Reset mid-run.
  - Stimulus: rst for 1 cycle while rom_addr=6 in SCAN.
  - Response: next cycle rom_en=0, busy=0, done=0, pass_count=0, no cell_valid afterwards. A following start restarts at address 0.
- Ignored events.
  - Stimulus: start during SCAN; pass_done_in during SCAN.
  - Response: no restart, no early DRAIN exit, pass_count unchanged.
  - Stimulus: start while in DONE.
  - Response: done drops the next cycle and a new sweep begins.

Source files
------------

// File: rtl/day4_scan_sched_if.sv
// Handshake bundle between the Day 4 sequencer and its surroundings
// (top-level start/done control, grid ROM, neighbour-count datapath).
interface day4_scan_sched_if #(
  parameter int ADDR_W = 15,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int PASS_W = 8
) ();
  logic              start;
  logic              mode;
  logic              rd_ready;
  logic              pass_done_in;
  logic [31:0]       pass_removed;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              cell_valid;
  logic [ROW_W-1:0]  cell_row;
  logic [COL_W-1:0]  cell_col;
  logic              pass_first;
  logic              pass_last;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_count;
  logic              overflow;

  // Controller side: issues start/mode and feeds datapath status.
  modport master (
    output start, mode, rd_ready, pass_done_in, pass_removed,
    input  rom_en, rom_addr, cell_valid, cell_row, cell_col,
           pass_first, pass_last, busy, done, pass_count, overflow
  );

  // Sequencer side.
  modport slave (
    input  start, mode, rd_ready, pass_done_in, pass_removed,
    output rom_en, rom_addr, cell_valid, cell_row, cell_col,
           pass_first, pass_last, busy, done, pass_count, overflow
  );
endinterface

// File: rtl/day4_scan_sched.sv
// Day 4 grid sweep sequencer: walks the ROM row-major, tags each returned
// cell with its position and pass boundaries, and in Part 2 repeats sweeps
// until a pass removes nothing or the pass limit is reached.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SCAN   | issuing ROM reads, one per rd_ready cycle
// DRAIN  | all reads issued, waiting for the datapath to report the pass
// DECIDE | choose between another sweep and finishing
// DONE   | run complete, done held until the next start
module day4_scan_sched #(
  parameter int ROWS       = 140,
  parameter int COLS       = 140,
  parameter int ADDR_W     = 15,
  parameter int ROW_W      = 8,
  parameter int COL_W      = 8,
  parameter int PASS_W     = 8,
  parameter int MAX_PASSES = 255
) (
  input logic              clk,
  input logic              rst,
  day4_scan_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_PASSES);
  localparam logic [PASS_W-1:0] PASS_SAT   = '1;

  state_t            state;
  logic              mode_q;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       removed_q;
  logic [PASS_W-1:0] pass_count;
  logic              overflow;
  logic              done;
  logic              cell_valid;
  logic [ROW_W-1:0]  cell_row;
  logic [COL_W-1:0]  cell_col;
  logic              pass_first;
  logic              pass_last;
  logic              rom_en;
  logic              busy;

  // Read strobe and busy decode straight from state so a stall or reset
  // takes effect in the same cycle.
  assign rom_en = (state == SCAN) && bus.rd_ready;
  assign busy   = (state == SCAN) || (state == DRAIN) || (state == DECIDE);

  // Sequencer FSM, address/row/col counters and the one-cycle cell tag
  // pipeline that lines up with the ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      row        <= '0;
      col        <= '0;
      addr       <= '0;
      removed_q  <= '0;
      pass_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      cell_valid <= 1'b0;
      cell_row   <= '0;
      cell_col   <= '0;
      pass_first <= 1'b0;
      pass_last  <= 1'b0;
    end else begin
      cell_valid <= rom_en;
      pass_first <= rom_en && (row == '0) && (col == '0);
      pass_last  <= rom_en && (addr == LAST_ADDR);
      if (rom_en) begin
        cell_row <= row;
        cell_col <= col;
      end

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= SCAN;
            mode_q     <= bus.mode;
            pass_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            row        <= '0;
            col        <= '0;
            addr       <= '0;
          end
        end
        SCAN: begin
          if (rom_en) begin
            // The last address is left in place; DECIDE clears it.
            if (addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              addr <= addr + 1'b1;
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (bus.pass_done_in) begin
            if (pass_count != PASS_SAT) pass_count <= pass_count + 1'b1;
            removed_q <= bus.pass_removed;
            state     <= DECIDE;
          end
        end
        DECIDE: begin
          if (!mode_q || (removed_q == 32'd0)) begin
            state <= DONE;
            done  <= 1'b1;
          end else if ((pass_count >= PASS_LIMIT) || (pass_count == PASS_SAT)) begin
            // A saturated counter also stops the run so it cannot spin forever.
            state    <= DONE;
            done     <= 1'b1;
            overflow <= 1'b1;
          end else begin
            state <= SCAN;
            row   <= '0;
            col   <= '0;
            addr  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_en     = rom_en;
  assign bus.rom_addr   = addr;
  assign bus.cell_valid = cell_valid;
  assign bus.cell_row   = cell_row;
  assign bus.cell_col   = cell_col;
  assign bus.pass_first = pass_first;
  assign bus.pass_last  = pass_last;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass_count = pass_count;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_day4_scan_sched.sv
// Bench for day4_scan_sched on a 3x4 grid. Expected read addresses are
// queued when a sweep is launched; each rom_en pops one and queues the
// expected cell tag, which the matching cell_valid pops and compares.
module tb_day4_scan_sched;
  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int NCELL = ROWS * COLS;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       first;
    logic       last;
  } cell_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  day4_scan_sched_if ia ();
  day4_scan_sched_if ib ();

  day4_scan_sched #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(15), .ROW_W(8), .COL_W(8),
    .PASS_W(8), .MAX_PASSES(255)
  ) u_a (.clk(clk), .rst(rst), .bus(ia.slave));

  day4_scan_sched #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(15), .ROW_W(8), .COL_W(8),
    .PASS_W(8), .MAX_PASSES(2)
  ) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_rd[$];
  cell_t exp_cell[$];
  bit    mon_on = 1'b0;
  logic  prev_rom_en = 1'b0;
  logic  prev_rst = 1'b0;
  int    cell_cnt = 0;
  int    mon_a;
  cell_t mon_c;
  cell_t mon_g;
  int    b_sweeps = 0;
  int    b_cells = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (mon_on) begin
      check_eq("cell_latency", 32'(ia.cell_valid), 32'(prev_rom_en && !prev_rst));
      if (ia.rom_en) begin
        check_eq("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          mon_a = exp_rd.pop_front();
          check_eq("rom_addr", 32'(ia.rom_addr), mon_a);
          mon_c.row   = 8'(mon_a / COLS);
          mon_c.col   = 8'(mon_a % COLS);
          mon_c.first = (mon_a == 0);
          mon_c.last  = (mon_a == NCELL - 1);
          exp_cell.push_back(mon_c);
        end
      end
      if (ia.cell_valid) begin
        cell_cnt++;
        check_eq("cell_expected", 32'(exp_cell.size() != 0), 1);
        if (exp_cell.size() != 0) begin
          mon_c = exp_cell.pop_front();
          mon_g = '{row: ia.cell_row, col: ia.cell_col,
                    first: ia.pass_first, last: ia.pass_last};
          check_eq("cell_tag", 32'(mon_g), 32'(mon_c));
        end
      end
    end
    prev_rom_en = ia.rom_en;
    prev_rst    = rst;
  end

  // Sweep counter for the pass-limited instance.
  always @(negedge clk) begin
    if (ib.cell_valid) begin
      b_cells++;
      if (ib.pass_first) b_sweeps++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NCELL; i++) exp_rd.push_back(i);
  endtask

  task automatic do_start(input logic m);
    ia.start = 1'b1;
    ia.mode  = m;
    tick();
    ia.start = 1'b0;
    ia.mode  = ~m;
    check_eq("start_busy", 32'(ia.busy), 1);
    check_eq("start_done_clr", 32'(ia.done), 0);
    check_eq("start_pc_clr", 32'(ia.pass_count), 0);
  endtask

  task automatic run_sweep(input bit bp, input bit inj);
    int k = 0;
    int last_k = 0;
    cell_cnt = 0;
    while (exp_rd.size() != 0 && k < 200) begin
      ia.rd_ready     = bp ? (k % 2 == 0) : 1'b1;
      ia.start        = inj && (k == 4);
      ia.pass_done_in = inj && (k == 4);
      @(negedge clk);
      if (ia.rom_en) last_k = k + 1;
      tick();
      k++;
    end
    ia.rd_ready     = 1'b1;
    ia.start        = 1'b0;
    ia.pass_done_in = 1'b0;
    check_eq("sweep_in_time", exp_rd.size(), 0);
    check_eq("last_rom_cycle", last_k, bp ? 2 * NCELL - 1 : NCELL);
    tick();
    check_eq("cell_count", cell_cnt, NCELL);
    check_eq("cells_drained", exp_cell.size(), 0);
    check_eq("drain_busy", 32'(ia.busy), 1);
    check_eq("drain_rom_en", 32'(ia.rom_en), 0);
  endtask

  task automatic finish_pass(input int removed, input bit expect_done,
                             input int exp_pc, input bit exp_ovf);
    repeat (3) tick();
    check_eq("drain_wait", 32'(ia.busy && !ia.done), 1);
    if (!expect_done) push_sweep();
    ia.pass_done_in = 1'b1;
    ia.pass_removed = removed;
    tick();
    ia.pass_done_in = 1'b0;
    ia.pass_removed = 0;
    check_eq("decide_busy", 32'(ia.busy), 1);
    check_eq("decide_done", 32'(ia.done), 0);
    check_eq("pass_count", 32'(ia.pass_count), exp_pc);
    tick();
    check_eq("end_done", 32'(ia.done), 32'(expect_done));
    check_eq("end_busy", 32'(ia.busy), 32'(!expect_done));
    check_eq("overflow", 32'(ia.overflow), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    ia.start = 0; ia.mode = 0; ia.rd_ready = 1; ia.pass_done_in = 0; ia.pass_removed = 0;
    ib.start = 0; ib.mode = 0; ib.rd_ready = 1; ib.pass_done_in = 0; ib.pass_removed = 0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_rom_en", 32'(ia.rom_en), 0);
    check_eq("rst_rom_addr", 32'(ia.rom_addr), 0);
    check_eq("rst_cell", 32'({ia.cell_valid, ia.cell_row, ia.cell_col, ia.pass_first, ia.pass_last}), 0);
    check_eq("rst_busy_done", 32'({ia.busy, ia.done}), 0);
    check_eq("rst_pc_ovf", 32'({ia.pass_count, ia.overflow}), 0);
    rst = 1'b0;
    tick();
    mon_on = 1'b1;

    // Part 1 single sweep; mode flipped after start must not matter.
    push_sweep();
    do_start(1'b0);
    run_sweep(1'b0, 1'b0);
    check_eq("p1_pc_before", 32'(ia.pass_count), 0);
    finish_pass(7, 1'b1, 1, 1'b0);
    repeat (2) tick();
    check_eq("done_held", 32'(ia.done), 1);

    // Restart from DONE, with alternating backpressure.
    push_sweep();
    do_start(1'b0);
    run_sweep(1'b1, 1'b0);
    finish_pass(0, 1'b1, 1, 1'b0);

    // Part 2 convergence: 5, 2, 0 removals; stray start/pass_done in sweep 2.
    push_sweep();
    do_start(1'b1);
    run_sweep(1'b0, 1'b0);
    finish_pass(5, 1'b0, 1, 1'b0);
    run_sweep(1'b0, 1'b1);
    check_eq("pc_unchanged", 32'(ia.pass_count), 1);
    finish_pass(2, 1'b0, 2, 1'b0);
    run_sweep(1'b0, 1'b0);
    finish_pass(0, 1'b1, 3, 1'b0);

    // Reset while rom_addr is 6.
    push_sweep();
    do_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ia.rom_addr == 15'd6) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("reached_addr6", 32'(found), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd.delete();
    exp_cell.delete();
    cell_cnt = 0;
    check_eq("mrst_rom_en", 32'(ia.rom_en), 0);
    check_eq("mrst_rom_addr", 32'(ia.rom_addr), 0);
    check_eq("mrst_busy_done", 32'({ia.busy, ia.done}), 0);
    check_eq("mrst_pc", 32'(ia.pass_count), 0);
    repeat (4) tick();
    check_eq("mrst_no_cells", cell_cnt, 0);
    push_sweep();
    do_start(1'b0);
    run_sweep(1'b0, 1'b0);
    finish_pass(3, 1'b1, 1, 1'b0);

    // Part 2 pass limit on the MAX_PASSES=2 instance, removals always 1.
    ib.pass_removed = 1;
    ib.pass_done_in = 1'b1;
    ib.mode  = 1'b1;
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ib.done) break;
      tick();
    end
    check_eq("lim_done", 32'(ib.done), 1);
    check_eq("lim_sweeps", b_sweeps, 2);
    check_eq("lim_cells", b_cells, 2 * NCELL);
    check_eq("lim_pass_count", 32'(ib.pass_count), 2);
    check_eq("lim_overflow", 32'(ib.overflow), 1);
    ib.pass_done_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
